cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Consumer end of the ALU flag interface.
- Captures the ALU's zero/negative/carry/overflow outputs into an architectural NZCV register when a flag-setting instruction executes.
- Evaluates the 4-bit B.cond condition code against those flags and returns a registered branch-taken decision to the PC-select logic.
- Sits between the ALU and the next-PC mux in the datapath.

Parameters:
- BYPASS, 1, when 1 a same-cycle flag write is forwarded into condition evaluation; when 0 evaluation always uses the stored flags.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- flags_we  input  1  ALU is executing a flag-setting op; driven from ALUControl[3].
- zero_in  input  1  ALU zero flag.
- negative_in  input  1  ALU negative flag.
- carry_in  input  1  ALU carry flag.
- overflow_in  input  1  ALU overflow flag.
- eval_valid  input  1  request to evaluate cond this cycle (B.cond in execute).
- cond  input  4  condition code, LEGv8/ARMv8 encoding.
- flush  input  1  squash any in-flight or same-cycle evaluation.
- nzcv  output  4  stored flags {N,Z,C,V}.
- taken  output  1  registered branch decision.
- taken_valid  output  1  taken is meaningful this cycle; one-cycle pulse.

Behaviour:
- Reset (reset==0 at a rising edge):
  - nzcv=4'b0000, taken=0, taken_valid=0.
  - Reset overrides every other input in that cycle.
- Flag register:
  - On an edge with flags_we=1, nzcv <= {negative_in, zero_in, carry_in, overflow_in}.
  - With flags_we=0, nzcv holds its value. Input flags are ignored even if nonzero.
  - flush does not block a flag write; flags are architectural once the ALU op commits.
- Effective flags F for evaluation:
  - BYPASS=1 and flags_we=1: F = the incoming flags.
  - Otherwise: F = the stored nzcv.
- Condition decode, pure combinational on F:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 HS: C
  - 0011 LO: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !(C&!Z)
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: !(!Z&(N==V))
  - 1110 AL: 1
  - 1111 NV: 1 (ARMv8 semantics: always)
- Evaluation pipeline, latency exactly 1 cycle:
  - On an edge with eval_valid=1 and flush=0: taken <= decode(cond, F), taken_valid <= 1.
  - On an edge with eval_valid=0 or flush=1: taken <= 0, taken_valid <= 0.
  - taken is forced to 0 whenever taken_valid=0. Consumers never see a stale 1.
  - Back-to-back eval_valid on consecutive cycles yields consecutive taken_valid pulses, each using that cycle's F.
- Flush:
  - flush in the same cycle as eval_valid drops that request.
  - flush while taken_valid=1 does not retract the already-presented output; it only affects the next edge.
- Reset mid-operation: a pending evaluation is discarded and flags are cleared. The first post-reset evaluation sees nzcv=0000, so EQ=0, NE=1, GE=1.
- X-safety: cond and the flag inputs are don't-care when eval_valid=0 and flags_we=0. Outputs must not become X from them.

Test Plan:
- Reset: hold reset=0 for 2 cycles with flags_we=1, flags=1111 -> nzcv=0000, taken=0, taken_valid=0. Release, eval_valid=1, cond=0001 (NE) -> next cycle taken_valid=1, taken=1.
- Flag capture: flags_we=1 with {N,Z,C,V}=0100 -> nzcv=0100 next cycle. Then flags_we=0 with inputs 1011 for 3 cycles -> nzcv stays 0100. Then eval EQ -> taken=1; NE -> taken=0.
- Bypass: stored nzcv=0000; same cycle flags_we=1 with Z=1 and eval_valid=1, cond=0000 -> BYPASS=1 gives taken=1. BYPASS=0 gives taken=0 and nzcv=0100 afterward.
- Signed/unsigned conditions:
  - nzcv=1000 (N=1,V=0): GE=0, LT=1, GT=0, LE=1.
  - nzcv=0010 (C=1,Z=0): HI=1, LS=0.
  - nzcv=0110: HI=0, LS=1.
- Flush and back-to-back: eval_valid=1 for 3 cycles with conds EQ, AL, NV and flush=1 on the second cycle -> taken_valid pulses =1,0,1. taken for the first and third equals the decode; AL is dropped. A flag write in the flushed cycle still updates nzcv.
- Exhaustive sweep: all 16 conds × 16 nzcv values, evaluated from the stored register -> taken matches the decode table for all 256 cases. AL and NV are always 1.

Source files
------------

// File: rtl/cond_unit.sv
// -----------------------------------------------------------------------------
// cond_unit
//   Consumer end of the ALU flag interface.
//   - Captures the ALU flags into the architectural NZCV register when a
//     flag-setting op executes.
//   - Evaluates a 4-bit B.cond condition code against the effective flags.
//   - Returns a registered branch-taken decision to the PC-select logic.
//
// Parameters
//   BYPASS       1: a same-cycle flag write feeds condition evaluation.
//                0: evaluation always uses the stored flags.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   flags_we     ALU flag-setting op this cycle
//   zero_in      ALU Z flag
//   negative_in  ALU N flag
//   carry_in     ALU C flag
//   overflow_in  ALU V flag
//   eval_valid   evaluate cond this cycle
//   cond         condition code (LEGv8/ARMv8 encoding)
//   flush        squash a same-cycle evaluation
//   nzcv         stored flags {N,Z,C,V}
//   taken        registered branch decision (0 whenever taken_valid is 0)
//   taken_valid  one-cycle pulse qualifying taken
// -----------------------------------------------------------------------------
module cond_unit #(
  parameter bit BYPASS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flags_we,
  input  logic       zero_in,
  input  logic       negative_in,
  input  logic       carry_in,
  input  logic       overflow_in,
  input  logic       eval_valid,
  input  logic [3:0] cond,
  input  logic       flush,
  output logic [3:0] nzcv,
  output logic       taken,
  output logic       taken_valid
);

  // Condition decode on a {N,Z,C,V} flag vector.
  function automatic logic decode_cond(input logic [3:0] c, input logic [3:0] f);
    logic n;
    logic z;
    logic cf;
    logic v;
    logic r;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cf;
      4'b0011: r = ~cf;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cf & ~z;
      4'b1001: r = ~(cf & ~z);
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = ~(~z & (n == v));
      4'b1110: r = 1'b1;
      4'b1111: r = 1'b1;  // NV behaves as always in ARMv8
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [3:0] nzcv_q;
  logic [3:0] nzcv_d;
  logic       taken_q;
  logic       taken_d;
  logic       taken_valid_q;
  logic       taken_valid_d;
  logic [3:0] in_flags_s;
  logic [3:0] eff_flags_s;
  logic       eval_go_s;

  assign in_flags_s = {negative_in, zero_in, carry_in, overflow_in};
  assign eval_go_s  = eval_valid & ~flush;

  // Select the flags seen by the decoder (forwarded or stored).
  always_comb begin
    eff_flags_s = nzcv_q;
    if (BYPASS && flags_we) begin
      eff_flags_s = in_flags_s;
    end else begin
      eff_flags_s = nzcv_q;
    end
  end

  // Next-state for the flag register and the evaluation stage.
  // Flag inputs and cond only reach state when their enables are high, so
  // undriven values on them cannot leak into the outputs.
  always_comb begin
    nzcv_d        = nzcv_q;
    taken_d       = 1'b0;
    taken_valid_d = 1'b0;
    // flush never blocks a committed flag write
    if (flags_we) begin
      nzcv_d = in_flags_s;
    end else begin
      nzcv_d = nzcv_q;
    end
    if (eval_go_s) begin
      taken_d       = decode_cond(cond, eff_flags_s);
      taken_valid_d = 1'b1;
    end else begin
      taken_d       = 1'b0;
      taken_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      nzcv_q        <= 4'b0000;
      taken_q       <= 1'b0;
      taken_valid_q <= 1'b0;
    end else begin
      nzcv_q        <= nzcv_d;
      taken_q       <= taken_d;
      taken_valid_q <= taken_valid_d;
    end
  end

  assign nzcv        = nzcv_q;
  assign taken       = taken_q;
  assign taken_valid = taken_valid_q;

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic       flags_we;
  logic       zero_in;
  logic       negative_in;
  logic       carry_in;
  logic       overflow_in;
  logic       eval_valid;
  logic [3:0] cond;
  logic       flush;
  logic [3:0] nzcv_b1;
  logic       taken_b1;
  logic       taken_valid_b1;
  logic [3:0] nzcv_b0;
  logic       taken_b0;
  logic       taken_valid_b0;

  int tests_run;
  int tests_failed;

  cond_unit #(.BYPASS(1'b1)) dut_b1 (
    .clk(clk), .reset(reset), .flags_we(flags_we),
    .zero_in(zero_in), .negative_in(negative_in),
    .carry_in(carry_in), .overflow_in(overflow_in),
    .eval_valid(eval_valid), .cond(cond), .flush(flush),
    .nzcv(nzcv_b1), .taken(taken_b1), .taken_valid(taken_valid_b1)
  );

  cond_unit #(.BYPASS(1'b0)) dut_b0 (
    .clk(clk), .reset(reset), .flags_we(flags_we),
    .zero_in(zero_in), .negative_in(negative_in),
    .carry_in(carry_in), .overflow_in(overflow_in),
    .eval_valid(eval_valid), .cond(cond), .flush(flush),
    .nzcv(nzcv_b0), .taken(taken_b0), .taken_valid(taken_valid_b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fw;
    logic [3:0] flags;   // {N,Z,C,V}
    logic       ev;
    logic [3:0] cnd;
    logic       fl;
    logic [3:0] exp_nzcv;
    logic       exp_t1;  // taken expected from BYPASS=1
    logic       exp_t0;  // taken expected from BYPASS=0
    logic       exp_tv;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic fw, input logic [3:0] f, input logic ev,
                       input logic [3:0] c, input logic fl);
    flags_we    = fw;
    negative_in = f[3];
    zero_in     = f[2];
    carry_in    = f[1];
    overflow_in = f[0];
    eval_valid  = ev;
    cond        = c;
    flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string name, input logic [3:0] en,
                            input logic et1, input logic et0, input logic etv);
    check({name, ".nzcv_b1"}, nzcv_b1, en);
    check({name, ".nzcv_b0"}, nzcv_b0, en);
    check({name, ".taken_b1"}, {3'b000, taken_b1}, {3'b000, et1});
    check({name, ".taken_b0"}, {3'b000, taken_b0}, {3'b000, et0});
    check({name, ".tv_b1"}, {3'b000, taken_valid_b1}, {3'b000, etv});
    check({name, ".tv_b0"}, {3'b000, taken_valid_b0}, {3'b000, etv});
  endtask

  // Reference decode written from the mnemonic meanings.
  function automatic logic ref_taken(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c == 4'd0)       return z == 1'b1;                       // EQ
    else if (c == 4'd1)  return z == 1'b0;                       // NE
    else if (c == 4'd2)  return cf == 1'b1;                      // HS
    else if (c == 4'd3)  return cf == 1'b0;                      // LO
    else if (c == 4'd4)  return n == 1'b1;                       // MI
    else if (c == 4'd5)  return n == 1'b0;                       // PL
    else if (c == 4'd6)  return v == 1'b1;                       // VS
    else if (c == 4'd7)  return v == 1'b0;                       // VC
    else if (c == 4'd8)  return (cf == 1'b1) && (z == 1'b0);     // HI
    else if (c == 4'd9)  return (cf == 1'b0) || (z == 1'b1);     // LS
    else if (c == 4'd10) return n == v;                          // GE
    else if (c == 4'd11) return n != v;                          // LT
    else if (c == 4'd12) return (z == 1'b0) && (n == v);         // GT
    else if (c == 4'd13) return (z == 1'b1) || (n != v);         // LE
    else                 return 1'b1;                            // AL, NV
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //            fw    flags   ev    cond     fl    nzcv     t1    t0    tv
    // flag capture and hold
    vecs[0]  = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1011, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 4'b1011, 1'b1, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0};
    // bypass: stored 0000, same-cycle Z=1 write with EQ evaluation
    vecs[7]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1};
    // signed: N=1 V=0
    vecs[9]  = '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 1'b1, 4'b1010, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 4'b1011, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 4'b0000, 1'b1, 4'b1100, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 4'b0000, 1'b1, 4'b1101, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1};
    // unsigned: C=1 Z=0 then C=1 Z=1
    vecs[14] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'b0000, 1'b1, 4'b1000, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 4'b0000, 1'b1, 4'b1001, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 4'b0110, 1'b0, 4'b0000, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 4'b0000, 1'b1, 4'b1000, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 4'b0000, 1'b1, 4'b1001, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b1};
    // flush in the middle of EQ, AL, NV; flag write in the flushed cycle
    vecs[20] = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1};
    vecs[22] = '{1'b1, 4'b0001, 1'b1, 4'b1110, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 4'b0000, 1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1};
    vecs[24] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1};
    vecs[25] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};

    // Reset held 2 cycles while flags are being written and an eval requested
    reset = 1'b0;
    drive(1'b1, 4'b1111, 1'b1, 4'b1110, 1'b0);
    tick();
    tick();
    check_both("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0);
    tick();
    check_both("post_reset_ne", 4'b0000, 1'b1, 1'b1, 1'b1);

    // Directed vector table, applied in sequence
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].fw, vecs[i].flags, vecs[i].ev, vecs[i].cnd, vecs[i].fl);
      tick();
      check_both($sformatf("vec%0d", i), vecs[i].exp_nzcv, vecs[i].exp_t1,
                 vecs[i].exp_t0, vecs[i].exp_tv);
    end

    // Flush while a result is presented must not retract it in that cycle
    drive(1'b0, 4'b0000, 1'b1, 4'b1110, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    #2;
    check_both("flush_hold", 4'b0001, 1'b1, 1'b1, 1'b1);
    tick();
    check_both("flush_after", 4'b0001, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation discards pending eval and clears flags
    drive(1'b1, 4'b1111, 1'b1, 4'b1110, 1'b0);
    reset = 1'b0;
    tick();
    check_both("mid_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0);
    tick();
    check_both("mid_reset_eq", 4'b0000, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 4'b1111, 1'b1, 4'b1010, 1'b0);
    tick();
    check_both("mid_reset_ge", 4'b0000, 1'b1, 1'b1, 1'b1);

    // Exhaustive sweep from the stored register
    for (int f = 0; f < 16; f++) begin
      drive(1'b1, f[3:0], 1'b0, 4'b0000, 1'b0);
      tick();
      for (int c = 0; c < 16; c++) begin
        drive(1'b0, ~f[3:0], 1'b1, c[3:0], 1'b0);
        tick();
        check_both($sformatf("sweep_f%0d_c%0d", f, c), f[3:0],
                   ref_taken(c[3:0], f[3:0]), ref_taken(c[3:0], f[3:0]), 1'b1);
      end
    end

    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
